// File: rtl/dec_entry_pkg.sv
// Shared types and BCD helpers for the numeric entry block.
package dec_entry_pkg;

  localparam int unsigned ACC_W = 14;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d >= BCD_MAX) ? 4'd0 : 4'(d + 4'd1);
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t d);
    return (d == 4'd0) ? BCD_MAX : 4'(d - 4'd1);
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Raw push-button conditioning: 2-FF synchroniser, stability debounce and
// a one-cycle pulse on each accepted press.
module btn_cond #(
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Level follows the synced input only after it has differed for DEB_CYCLES clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync2;
        pulse <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dec_entry.sv
// Four-digit BCD operator entry with cursor editing and BCD->binary conversion.
module dec_entry
  import dec_entry_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_ok,
  output logic [15:0] digits,
  output logic [1:0]  cursor,
  output logic        busy,
  output logic [15:0] data_out,
  output logic        data_valid
);

  logic p_up, p_down, p_left, p_right, p_ok;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_up    (.clk(clk), .rst(rst), .raw(btn_up),    .pulse(p_up));
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_down  (.clk(clk), .rst(rst), .raw(btn_down),  .pulse(p_down));
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_left  (.clk(clk), .rst(rst), .raw(btn_left),  .pulse(p_left));
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_right (.clk(clk), .rst(rst), .raw(btn_right), .pulse(p_right));
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_ok    (.clk(clk), .rst(rst), .raw(btn_ok),    .pulse(p_ok));

  state_t           state, state_n;
  logic [15:0]      digits_n;
  logic [1:0]       cursor_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [1:0]       idx, idx_n;
  logic [15:0]      data_out_n;
  logic [3:0]       cur_base;
  logic [3:0]       idx_base;
  bcd_t             cur_digit;
  bcd_t             idx_digit;

  assign cur_base  = {cursor, 2'b00};
  assign idx_base  = {idx, 2'b00};
  assign cur_digit = digits[cur_base +: 4];
  assign idx_digit = digits[idx_base +: 4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EDIT;
      digits     <= '0;
      cursor     <= '0;
      acc        <= '0;
      idx        <= '0;
      data_out   <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      digits     <= digits_n;
      cursor     <= cursor_n;
      acc        <= acc_n;
      idx        <= idx_n;
      data_out   <= data_out_n;
      busy       <= (state_n != EDIT);
      data_valid <= (state == DONE);
    end
  end

  // Edit actions are mutually exclusive per cycle; pulses outside EDIT are dropped.
  always_comb begin
    state_n    = state;
    digits_n   = digits;
    cursor_n   = cursor;
    acc_n      = acc;
    idx_n      = idx;
    data_out_n = data_out;
    case (state)
      EDIT: begin
        if (p_ok) begin
          acc_n   = '0;
          idx_n   = 2'd3;
          state_n = CONV;
        end else if (p_up) begin
          digits_n[cur_base +: 4] = bcd_inc(cur_digit);
        end else if (p_down) begin
          digits_n[cur_base +: 4] = bcd_dec(cur_digit);
        end else if (p_left) begin
          cursor_n = 2'(cursor + 2'd1);
        end else if (p_right) begin
          cursor_n = 2'(cursor - 2'd1);
        end
      end
      CONV: begin
        // Horner step, most significant digit first; 9999 fits in ACC_W bits.
        acc_n = ACC_W'(acc * ACC_W'(10)) + ACC_W'(idx_digit);
        if (idx == 2'd0) state_n = DONE;
        else             idx_n   = 2'(idx - 2'd1);
      end
      DONE: begin
        data_out_n = {2'b00, acc};
        state_n    = EDIT;
      end
      default: state_n = EDIT;
    endcase
  end

endmodule
